mc14500b_run_ctrl: RTL and testbench

//   Run/step/reset sequencer for the MC14500B demo core; replaces the free-running

---
 rtl/mc14500b_run_ctrl.sv | 131 +++++++++++++
 tb/tb_mc14500b_run_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc14500b_run_ctrl.sv
// rtl/mc14500b_run_ctrl.sv - run/step/reset sequencer producing X2 and CPU reset for the MC14500B core
// One fabric-clock FSM; every output is a flop, so X2 never sees an input combinationally.
module mc14500b_run_ctrl #(
  parameter int HALF_BASE  = 524288,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_tgl_i,
  input  logic             step_i,
  input  logic             sreset_i,
  input  logic             flg0_i,
  input  logic [1:0]       speed_i,
  output logic             x2_o,
  output logic             cpu_rst_o,
  output logic             running_o,
  output logic [CNT_W-1:0] edge_cnt_o
);

  localparam int DIV_W = $clog2(HALF_BASE) + 1;
  localparam int RC_W  = $clog2(RST_CYCLES + 2);

  typedef enum logic [2:0] {
    S_RESET,
    S_HALT,
    S_RUN,
    S_STEP_HI,
    S_STEP_LO
  } state_t;

  state_t           state_q;
  logic             x2_q;
  logic             cpu_rst_q;
  logic             running_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [RC_W-1:0]  rise_q;
  logic             armed_q;
  logic             stop_q;

  logic [DIV_W-1:0] shifted;
  logic [DIV_W-1:0] half_len;
  logic             half_done;

  // Clamp to one cycle so a small HALF_BASE at high speed never yields a zero-length half.
  always_comb begin
    shifted   = DIV_W'(HALF_BASE) >> {speed_i, 1'b0};
    half_len  = (shifted == '0) ? DIV_W'(1) : shifted;
    half_done = (div_q >= (half_len - DIV_W'(1)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || sreset_i) begin
      state_q    <= S_RESET;
      x2_q       <= 1'b0;
      cpu_rst_q  <= 1'b1;
      running_q  <= 1'b0;
      edge_cnt_q <= '0;
      div_q      <= '0;
      rise_q     <= '0;
      armed_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      case (state_q)
        S_HALT: begin
          div_q <= '0;
          if (run_tgl_i) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            armed_q   <= 1'b0;
            stop_q    <= 1'b0;
          end else if (step_i) begin
            state_q    <= S_STEP_HI;
            x2_q       <= 1'b1;
            edge_cnt_q <= edge_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (state_q == S_RUN && run_tgl_i) stop_q <= 1'b1;
          if (!half_done) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            case (state_q)
              S_RESET: begin
                if (!x2_q) begin
                  x2_q   <= 1'b1;
                  rise_q <= rise_q + RC_W'(1);
                end else begin
                  x2_q <= 1'b0;
                  if (rise_q >= RC_W'(RST_CYCLES)) begin
                    state_q   <= S_HALT;
                    cpu_rst_q <= 1'b0;
                  end
                end
              end
              S_RUN: begin
                if (!x2_q) begin
                  x2_q       <= 1'b1;
                  edge_cnt_q <= edge_cnt_q + CNT_W'(1);
                  // FLG0 is ignored until one full period has completed in this run.
                  if (armed_q && flg0_i) stop_q <= 1'b1;
                end else begin
                  x2_q    <= 1'b0;
                  armed_q <= 1'b1;
                  if (stop_q || run_tgl_i) begin
                    state_q   <= S_HALT;
                    running_q <= 1'b0;
                  end
                end
              end
              S_STEP_HI: begin
                x2_q    <= 1'b0;
                state_q <= S_STEP_LO;
              end
              S_STEP_LO: state_q <= S_HALT;
              default:   state_q <= S_HALT;
            endcase
          end
        end
      endcase
    end
  end

  assign x2_o       = x2_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign running_o  = running_q;
  assign edge_cnt_o = edge_cnt_q;

endmodule

// File: tb/tb_mc14500b_run_ctrl.sv
// tb/tb_mc14500b_run_ctrl.sv - bench for mc14500b_run_ctrl against a phase-level reference model
// Directed scenarios followed by randomized pulses; every cycle is compared to the model.
module tb_mc14500b_run_ctrl;

  localparam int HB      = 16;
  localparam int RC      = 4;
  localparam int CW      = 5;
  localparam int CNT_MOD = 1 << CW;

  localparam int M_BOOT = 0;
  localparam int M_IDLE = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run_tgl = 1'b0;
  logic          step = 1'b0;
  logic          sreset = 1'b0;
  logic          flg0 = 1'b0;
  logic [1:0]    speed = 2'd0;
  logic          x2_o;
  logic          cpu_rst_o;
  logic          running_o;
  logic [CW-1:0] edge_cnt_o;

  always #5 clk = ~clk;

  mc14500b_run_ctrl #(
    .HALF_BASE (HB),
    .RST_CYCLES(RC),
    .CNT_W     (CW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .run_tgl_i (run_tgl),
    .step_i    (step),
    .sreset_i  (sreset),
    .flg0_i    (flg0),
    .speed_i   (speed),
    .x2_o      (x2_o),
    .cpu_rst_o (cpu_rst_o),
    .running_o (running_o),
    .edge_cnt_o(edge_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_mode = M_BOOT;
  int m_lvl = 0;
  int m_ph = 0;
  int m_rstout = 1;
  int m_cnt = 0;
  int m_boot_rises = 0;
  int m_armed = 0;
  int m_stop = 0;

  int rises = 0;
  logic prev_x2 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model thinks in half-phases: how long the current level has lasted and what ends it.
  task automatic model_step();
    int h;
    h = HB >> (2 * speed);
    if (h < 1) h = 1;
    if (rst || sreset) begin
      m_mode = M_BOOT; m_lvl = 0; m_ph = 0; m_rstout = 1; m_cnt = 0;
      m_boot_rises = 0; m_armed = 0; m_stop = 0;
    end else if (m_mode == M_IDLE) begin
      if (run_tgl) begin
        m_mode = M_RUN; m_armed = 0; m_stop = 0;
      end else if (step) begin
        m_mode = M_STEP; m_lvl = 1; m_cnt = (m_cnt + 1) % CNT_MOD;
      end
    end else begin
      if (m_mode == M_RUN && run_tgl) m_stop = 1;
      m_ph++;
      if (m_ph >= h) begin
        m_ph = 0;
        if (m_mode == M_BOOT) begin
          if (m_lvl == 0) begin
            m_lvl = 1; m_boot_rises++;
          end else begin
            m_lvl = 0;
            if (m_boot_rises >= RC) begin m_mode = M_IDLE; m_rstout = 0; end
          end
        end else if (m_mode == M_RUN) begin
          if (m_lvl == 0) begin
            m_lvl = 1; m_cnt = (m_cnt + 1) % CNT_MOD;
            if (m_armed != 0 && flg0) m_stop = 1;
          end else begin
            m_lvl = 0; m_armed = 1;
            if (m_stop != 0) m_mode = M_IDLE;
          end
        end else begin
          if (m_lvl == 1) m_lvl = 0;
          else m_mode = M_IDLE;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (!prev_x2 && x2_o) rises++;
    prev_x2 = x2_o;
    check_eq("x2", 32'(x2_o), 32'(m_lvl));
    check_eq("cpu_rst", 32'(cpu_rst_o), 32'(m_rstout));
    check_eq("running", 32'(running_o), 32'(m_mode == M_RUN));
    check_eq("edge_cnt", 32'(edge_cnt_o), 32'(m_cnt));
  endtask

  task automatic pulse(input logic p_rt, input logic p_st, input logic p_sr);
    run_tgl = p_rt; step = p_st; sreset = p_sr;
    tick();
    run_tgl = 1'b0; step = 1'b0; sreset = 1'b0;
  endtask

  task automatic wait_rise(input int budget);
    int r0;
    int n;
    r0 = rises;
    n = 0;
    while (rises == r0 && n < budget) begin tick(); n++; end
    if (rises == r0) check_eq("rise_timeout", 32'(rises - r0), 32'd1);
  endtask

  task automatic measure_boot(input string tag);
    int n;
    n = 0;
    rises = 0;
    while (cpu_rst_o === 1'b1 && n < 400) begin tick(); n++; end
    check_eq({tag, "_len"}, 32'(n), 32'd128);
    check_eq({tag, "_rises"}, 32'(rises), 32'd4);
    check_eq({tag, "_x2"}, 32'(x2_o), 32'd0);
    check_eq({tag, "_running"}, 32'(running_o), 32'd0);
    check_eq({tag, "_cnt"}, 32'(edge_cnt_o), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int r0;
    logic exp_lvl;

    // 1: power-on reset and boot sequence
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_x2", 32'(x2_o), 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_eq("rst_cnt", 32'(edge_cnt_o), 32'd0);
    rst = 1'b0;
    measure_boot("boot");
    repeat (10) tick();
    check_eq("halt_hold_x2", 32'(x2_o), 32'd0);

    // 2: single step, second STEP during the high phase is ignored
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("step_x2_now", 32'(x2_o), 32'd1);
    n = 0;
    while (x2_o === 1'b1 && n < 100) begin
      step = (n == 8);
      tick();
      n++;
    end
    step = 1'b0;
    check_eq("step_hi_len", 32'(n), 32'd16);
    repeat (40) tick();
    check_eq("step_x2_after", 32'(x2_o), 32'd0);
    check_eq("step_cnt", 32'(edge_cnt_o), 32'd1);

    // 3: run ten periods, stop request mid-high
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) wait_rise(100);
    repeat (5) tick();
    check_eq("run_running", 32'(running_o), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("stop_x2_still_hi", 32'(x2_o), 32'd1);
    repeat (40) tick();
    check_eq("stop_x2", 32'(x2_o), 32'd0);
    check_eq("stop_running", 32'(running_o), 32'd0);
    check_eq("stop_cnt", 32'(edge_cnt_o), 32'd11);

    // 4: speed change mid-period
    pulse(1'b1, 1'b0, 1'b0);
    wait_rise(100);
    repeat (9) tick();
    speed = 2'd2;
    tick();
    check_eq("spd_toggle", 32'(x2_o), 32'd0);
    exp_lvl = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_lvl = ~exp_lvl;
      check_eq("spd_fast", 32'(x2_o), 32'(exp_lvl));
    end
    speed = 2'd0;
    wait_rise(100);
    n = 0;
    while (x2_o === 1'b1 && n < 100) begin tick(); n++; end
    check_eq("spd_slow_len", 32'(n), 32'd16);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (50) tick();
    check_eq("spd_stop", 32'(running_o), 32'd0);

    // 5: halt on FLG0, then re-run with FLG0 still high
    base = m_cnt;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) wait_rise(100);
    flg0 = 1'b1;
    n = 0;
    while (running_o === 1'b1 && n < 200) begin tick(); n++; end
    check_eq("flg_cnt", 32'(edge_cnt_o), 32'((base + 5) % CNT_MOD));
    check_eq("flg_x2", 32'(x2_o), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    r0 = rises;
    n = 0;
    while (running_o === 1'b1 && n < 300) begin tick(); n++; end
    check_eq("flg_rerun_rises", 32'(rises - r0), 32'd2);
    flg0 = 1'b0;

    // 6: SRESET beats RUN_TGL in the same cycle
    pulse(1'b1, 1'b0, 1'b0);
    repeat (20) tick();
    pulse(1'b1, 1'b0, 1'b1);
    check_eq("srst_x2", 32'(x2_o), 32'd0);
    check_eq("srst_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check_eq("srst_cnt", 32'(edge_cnt_o), 32'd0);
    check_eq("srst_running", 32'(running_o), 32'd0);
    measure_boot("sboot");

    // Counter wrap at the fastest speed
    pulse(1'b1, 1'b0, 1'b0);
    speed = 2'd3;
    repeat (100) tick();
    speed = 2'd0;

    // Randomized pulses and levels
    for (int i = 0; i < 4000; i++) begin
      rst     = ($urandom % 500) == 0;
      sreset  = ($urandom % 300) == 0;
      run_tgl = ($urandom % 50) == 0;
      step    = ($urandom % 30) == 0;
      if (($urandom % 40) == 0) flg0 = ~flg0;
      if (($urandom % 150) == 0) speed = 2'($urandom % 4);
      tick();
    end
    rst = 1'b0; sreset = 1'b0; run_tgl = 1'b0; step = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
